// File: rtl/line_mem_responder_pkg.sv
// Shared definitions for the line memory responder: FSM state encoding,
// address-split helpers and the beat-count type for the default geometry.
package mem_if_pkg;

   // FSM state encoding
   typedef logic [2:0] mem_state_t;
   localparam mem_state_t S_IDLE     = 3'd0;
   localparam mem_state_t S_RD_WAIT  = 3'd1;
   localparam mem_state_t S_RD_BURST = 3'd2;
   localparam mem_state_t S_WR_BURST = 3'd3;
   localparam mem_state_t S_WR_WAIT  = 3'd4;
   localparam mem_state_t S_WR_ACK   = 3'd5;

   // Default geometry and the address split it implies
   localparam int DEF_NUM_MEM_LOCS   = 64;
   localparam int DEF_WORDS_PER_LINE = 4;
   localparam int WORD_IDX_BITS      = $clog2(DEF_NUM_MEM_LOCS);
   localparam int LINE_OFF_BITS      = $clog2(DEF_WORDS_PER_LINE);

   // Beat counter holds 0..WORDS_PER_LINE inclusive
   typedef logic [LINE_OFF_BITS:0] beat_cnt_t;

   // Latency counter width: enough for 0..MEM_LATENCY-1, never narrower than 1
   function automatic int lat_cnt_bits(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Cache <-> memory line refill/writeback bus. The cache is the master,
// the responder is the slave.
interface line_mem_responder_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   import mem_if_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  wdata_valid;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wdata_ready;
   logic                  rdata_valid;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rdata_last;
   logic                  wr_done;
   logic                  busy;

   modport master (
      output req_valid, req_write, req_addr, wdata_valid, wdata,
      input  req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, wdata_valid, wdata,
      output req_ready, wdata_ready, rdata_valid, rdata, rdata_last, wr_done, busy
   );

endinterface

// File: rtl/line_mem_responder_mem_word_array.sv
// Backing word store: synchronous write, combinational read, single address.
// With MEM_RESET_CLEAR_EN defined, rstn low clears every word asynchronously;
// otherwise reset leaves the contents alone.
module mem_word_array
   import mem_if_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 32,
   parameter int AW     = 6
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

`ifdef MEM_RESET_CLEAR_EN
   // Word write, with whole-array clear while reset is asserted
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we) begin
         mem_q[addr] <= wdata;
      end
   end
`else
   logic unused_rstn;
   assign unused_rstn = rstn;

   // Word write; contents survive reset
   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end
`endif

   assign rdata = mem_q[addr];

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for cache line refills and writebacks.
// Refills stream WORDS_PER_LINE beats after MEM_LATENCY wait cycles;
// writebacks accept beats (with bubbles) and pulse wr_done after the same wait.
// Optional MEM_RESET_CLEAR_EN makes reset also zero the backing array.
module line_mem_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_MEM_LOCS   = 64,
   parameter int WORDS_PER_LINE = 4,
   parameter int MEM_LATENCY    = 4
) (
   input  logic                clk,
   input  logic                rstn,
   line_mem_responder_if.slave bus
);

   localparam int WIDX_W = $clog2(NUM_MEM_LOCS);
   localparam int LOFF_W = $clog2(WORDS_PER_LINE);
   localparam int BEAT_W = LOFF_W + 1;
   localparam int LAT_W  = lat_cnt_bits(MEM_LATENCY);

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS_PER_LINE - 1);
   localparam logic [BEAT_W-1:0] BEAT_ALL  = BEAT_W'(WORDS_PER_LINE);
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);
   localparam logic [WIDX_W-1:0] LINE_MASK = ~(WIDX_W'(WORDS_PER_LINE - 1));

   mem_state_t            state_q, state_d;
   logic [WIDX_W-1:0]     base_q, base_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [LAT_W-1:0]      lat_q, lat_d;
   logic                  rdata_valid_q, rdata_valid_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  rdata_last_q, rdata_last_d;
   logic                  wr_done_q, wr_done_d;

   logic [ADDR_WIDTH-1:0] addr_w;
   logic [WIDX_W-1:0]     line_base;
   logic [WIDX_W-1:0]     mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Byte and line-offset bits drop out; upper bits wrap modulo the array
   assign addr_w    = bus.req_addr;
   assign line_base = addr_w[WIDX_W+1:2] & LINE_MASK;
   assign mem_addr  = base_q + WIDX_W'(beat_q);
   assign mem_we    = (state_q == S_WR_BURST) && bus.wdata_valid;

   mem_word_array #(
      .DEPTH  (NUM_MEM_LOCS),
      .DATA_W (DATA_WIDTH),
      .AW     (WIDX_W)
   ) u_array (
      .clk   (clk),
      .rstn  (rstn),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (bus.wdata),
      .rdata (mem_rdata)
   );

   // Next-state, counter and output decode
   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      beat_d        = beat_q;
      lat_d         = lat_q;
      rdata_valid_d = 1'b0;
      rdata_d       = rdata_q;
      rdata_last_d  = 1'b0;
      wr_done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               base_d = line_base;
               beat_d = '0;
               lat_d  = '0;
               if (bus.req_write)      state_d = S_WR_BURST;
               else if (MEM_LATENCY == 0) state_d = S_RD_BURST;
               else                    state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (lat_q == LAT_LAST) begin
               lat_d   = '0;
               state_d = S_RD_BURST;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_RD_BURST: begin
            // Stay one cycle past the last beat so req_ready rises after it
            if (beat_q == BEAT_ALL) begin
               beat_d  = '0;
               state_d = S_IDLE;
            end else begin
               rdata_valid_d = 1'b1;
               rdata_d       = mem_rdata;
               rdata_last_d  = (beat_q == BEAT_LAST);
               beat_d        = beat_q + 1'b1;
            end
         end
         S_WR_BURST: begin
            if (bus.wdata_valid) begin
               if (beat_q == BEAT_LAST) begin
                  beat_d  = '0;
                  state_d = (MEM_LATENCY == 0) ? S_WR_ACK : S_WR_WAIT;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         S_WR_WAIT: begin
            if (lat_q == LAT_LAST) begin
               lat_d   = '0;
               state_d = S_WR_ACK;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         S_WR_ACK: begin
            wr_done_d = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= S_IDLE;
         base_q        <= '0;
         beat_q        <= '0;
         lat_q         <= '0;
         rdata_valid_q <= 1'b0;
         rdata_q       <= '0;
         rdata_last_q  <= 1'b0;
         wr_done_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         beat_q        <= beat_d;
         lat_q         <= lat_d;
         rdata_valid_q <= rdata_valid_d;
         rdata_q       <= rdata_d;
         rdata_last_q  <= rdata_last_d;
         wr_done_q     <= wr_done_d;
      end
   end

   assign bus.req_ready   = (state_q == S_IDLE);
   assign bus.wdata_ready = (state_q == S_WR_BURST);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.rdata_valid = rdata_valid_q;
   assign bus.rdata       = rdata_q;
   assign bus.rdata_last  = rdata_last_q;
   assign bus.wr_done     = wr_done_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder: one instance at MEM_LATENCY=4,
// one at MEM_LATENCY=0, sharing stimulus and selected by sel_s.
module tb_line_mem_responder;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   int          cyc = 0;
   int          nchk = 0;
   int          nfail = 0;

   bit          sel_s = 1'b0;
   logic        req_valid_s = 1'b0;
   logic        req_write_s = 1'b0;
   logic [31:0] req_addr_s = '0;
   logic        wdata_valid_s = 1'b0;
   logic [31:0] wdata_s = '0;

   logic [31:0] model [2][64];
   logic [31:0] expq [$];

   line_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ia ();
   line_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ib ();

   assign ia.req_valid   = req_valid_s & ~sel_s;
   assign ib.req_valid   = req_valid_s & sel_s;
   assign ia.wdata_valid = wdata_valid_s & ~sel_s;
   assign ib.wdata_valid = wdata_valid_s & sel_s;
   assign ia.req_write   = req_write_s;
   assign ib.req_write   = req_write_s;
   assign ia.req_addr    = req_addr_s;
   assign ib.req_addr    = req_addr_s;
   assign ia.wdata       = wdata_s;
   assign ib.wdata       = wdata_s;

   line_mem_responder #(.MEM_LATENCY(4)) dut_a (.clk(clk), .rstn(rstn), .bus(ia));
   line_mem_responder #(.MEM_LATENCY(0)) dut_b (.clk(clk), .rstn(rstn), .bus(ib));

   wire        o_req_ready   = sel_s ? ib.req_ready   : ia.req_ready;
   wire        o_wdata_ready = sel_s ? ib.wdata_ready : ia.wdata_ready;
   wire        o_rdata_valid = sel_s ? ib.rdata_valid : ia.rdata_valid;
   wire [31:0] o_rdata       = sel_s ? ib.rdata       : ia.rdata;
   wire        o_rdata_last  = sel_s ? ib.rdata_last  : ia.rdata_last;
   wire        o_wr_done     = sel_s ? ib.wr_done     : ia.wr_done;
   wire        o_busy        = sel_s ? ib.busy        : ia.busy;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int line_idx(input logic [31:0] addr);
      return int'((addr >> 2) & 32'd63) & ~3;
   endfunction

   task automatic clear_model;
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 64; i++)
`ifdef MEM_RESET_CLEAR_EN
            model[s][i] = 32'h0;
`else
            model[s][i] = 32'hx;
`endif
   endtask

   // Writeback of bd, bd+1, .. driven with bubble pattern pat (bit0 first)
   task automatic write_line(input bit s, input logic [31:0] addr,
                             input logic [31:0] bd, input logic [6:0] pat);
      int lat, widx, k, i, last, n;
      sel_s = s;
      lat   = s ? 0 : 4;
      widx  = line_idx(addr);
      chk("wr_req_ready", o_req_ready, 1);
      req_valid_s = 1'b1; req_write_s = 1'b1; req_addr_s = addr;
      tick;
      req_valid_s = 1'b0; req_write_s = 1'b0;
      k = 0; i = 0;
      while (k < 4 && i < 7) begin
         chk("wr_wdata_ready", o_wdata_ready, 1);
         chk("wr_busy", o_busy, 1);
         wdata_valid_s = pat[i];
         wdata_s       = bd + k;
         tick;
         if (pat[i]) begin
            model[s][widx + k] = bd + k;
            k++;
         end
         i++;
      end
      wdata_valid_s = 1'b0;
      wdata_s       = 32'hDEAD_BEEF;
      last = cyc;
      n = 0;
      while (o_wr_done !== 1'b1 && n < 20) begin tick; n++; end
      chk("wr_done_lat", 32'(cyc - last), 32'(lat + 1));
      chk("wr_done_idle", o_busy, 0);
      tick;
      chk("wr_done_pulse", o_wr_done, 0);
   endtask

   // Refill; keep leaves req_valid asserted through the whole burst
   task automatic read_line(input bit s, input logic [31:0] addr, input bit keep);
      int lat, widx, acc, n;
      logic [31:0] exp;
      sel_s = s;
      lat   = s ? 0 : 4;
      widx  = line_idx(addr);
      chk("rd_req_ready", o_req_ready, 1);
      for (int k = 0; k < 4; k++) expq.push_back(model[s][widx + k]);
      req_valid_s = 1'b1; req_write_s = 1'b0; req_addr_s = addr;
      tick;
      acc = cyc;
      if (!keep) req_valid_s = 1'b0;
      n = 0;
      while (o_rdata_valid !== 1'b1 && n < 20) begin
         chk("rd_wait_ready", o_req_ready, 0);
         tick; n++;
      end
      chk("rd_first_lat", 32'(cyc - acc), 32'(lat + 1));
      for (int b = 0; b < 4; b++) begin
         exp = (expq.size() > 0) ? expq.pop_front() : 32'hx;
         chk("rd_valid", o_rdata_valid, 1);
         chk("rd_busy_ready", o_req_ready, 0);
         chk("rd_data", o_rdata, exp);
         chk("rd_last", o_rdata_last, 32'(b == 3));
         tick;
      end
      chk("rd_end_valid", o_rdata_valid, 0);
      chk("rd_end_ready", o_req_ready, 1);
   endtask

   initial begin
      clear_model();
      rstn = 1'b0;
      repeat (3) tick;
      // Reset state
      chk("rst_req_ready", ia.req_ready, 1);
      chk("rst_wdata_ready", ia.wdata_ready, 0);
      chk("rst_rdata_valid", ia.rdata_valid, 0);
      chk("rst_rdata", ia.rdata, 0);
      chk("rst_rdata_last", ia.rdata_last, 0);
      chk("rst_wr_done", ia.wr_done, 0);
      chk("rst_busy", ia.busy, 0);
      chk("rst_busy_b", ib.busy, 0);
      rstn = 1'b1;
      tick;

`ifdef MEM_RESET_CLEAR_EN
      read_line(0, 32'h80, 0);
`endif

      // Writeback then refill of the same line via a different offset
      write_line(0, 32'h10, 32'hA0, 7'b1111111);
      read_line(0, 32'h1C, 0);

      // Neighbour lines, then a backpressured rewrite of the middle line
      write_line(0, 32'h00, 32'h10, 7'b1111111);
      write_line(0, 32'h20, 32'h30, 7'b1111111);
      write_line(0, 32'h10, 32'hB0, 7'b1011001);
      read_line(0, 32'h00, 0);
      read_line(0, 32'h10, 1);
      read_line(0, 32'h20, 0);

      // Address wrap and ignored low bits
      read_line(0, 32'h110, 0);
      read_line(0, 32'h13, 0);

      // wdata_valid while idle must not write
      sel_s = 1'b0;
      wdata_valid_s = 1'b1; wdata_s = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         chk("idle_wdata_ready", o_wdata_ready, 0);
         chk("idle_busy", o_busy, 0);
         tick;
      end
      wdata_valid_s = 1'b0;
      read_line(0, 32'h10, 0);

      // Reset during the second refill beat
      sel_s = 1'b0;
      req_valid_s = 1'b1; req_write_s = 1'b0; req_addr_s = 32'h20;
      tick;
      req_valid_s = 1'b0;
      for (int n = 0; n < 20 && o_rdata_valid !== 1'b1; n++) tick;
      tick;
      chk("mid_second_beat", o_rdata, model[0][9]);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", o_rdata_valid, 0);
      chk("mid_rst_busy", o_busy, 0);
      chk("mid_rst_ready", o_req_ready, 1);
      chk("mid_rst_last", o_rdata_last, 0);
      chk("mid_rst_rdata", o_rdata, 0);
      clear_model_on_reset();
      tick; tick;
      rstn = 1'b1;
      tick;
      chk("post_rst_ready", o_req_ready, 1);
      write_line(0, 32'h30, 32'hE0, 7'b1111111);
      read_line(0, 32'h30, 0);
`ifdef MEM_RESET_CLEAR_EN
      read_line(0, 32'h20, 0);
`else
      read_line(0, 32'h24, 0);
`endif

      // Zero-latency instance
      write_line(1, 32'h40, 32'hC0, 7'b1111111);
      read_line(1, 32'h44, 0);
      write_line(1, 32'h40, 32'hD0, 7'b1100101);
      read_line(1, 32'h4C, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

   task automatic clear_model_on_reset;
`ifdef MEM_RESET_CLEAR_EN
      clear_model();
`endif
   endtask

endmodule
